// File: rtl/ysyx_22041207_pkg.sv
// Shared definitions for the ysyx_22041207 instruction-fetch slice.
package ysyx_22041207_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned PC_INC           = 4;

    typedef struct packed {
        logic [63:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041207_fetch_fifo.sv
// Generic synchronous FIFO: push, pop, flush, occupancy count and head data.
module ysyx_22041207_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage carries no reset; the count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_data;
    end

    assign o_data  = r_mem[r_head];
    assign o_count = r_count;

    assert property (@(posedge clk) disable iff (rst) !(w_push && r_count == CW'(DEPTH)));

endmodule

// File: rtl/ysyx_22041207_ifu_prefetch.sv
// Instruction-fetch unit: credit-limited sequential prefetch into a queue, redirect flush.
module ysyx_22041207_ifu_prefetch
    import ysyx_22041207_pkg::*;
#(
    parameter int unsigned     XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     FQ_DEPTH        = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [63:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = XLEN + INST_W;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;

    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic [OW-1:0]   w_occupancy;
    logic            w_fire;
    logic            w_resp_accept;
    logic            w_push;
    logic            w_inst_valid;
    logic [31:0]     w_resp_word;

    assign w_target = redirect_pc & ~XLEN'(3);

    // Slots already promised: queued entries plus in-flight responses that will be kept.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_out} - {1'b0, r_drop};

    assign imem_req_valid = !rst && !redirect_valid
                         && (r_out < CW'(MAX_OUTSTANDING))
                         && (w_occupancy < OW'(FQ_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_resp_accept = imem_resp_valid && (r_out != '0);
    assign w_push        = w_resp_accept && (r_drop == '0) && !redirect_valid;
    assign w_resp_word   = r_resp_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop     <= r_out - CW'(w_resp_accept);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_INC);
                if (w_push) r_resp_pc  <= r_resp_pc + XLEN'(PC_INC);
                if (w_resp_accept && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
            r_out <= r_out + CW'(w_fire) - CW'(w_resp_accept);
        end
    end

    ysyx_22041207_fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_inst_valid && inst_ready),
        .i_flush (redirect_valid),
        .i_data  ({r_resp_pc, w_resp_word}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_inst_valid = (w_count != '0);
    assign inst_valid   = w_inst_valid;
    assign inst_o       = w_inst_valid ? w_head[INST_W-1:0] : '0;
    assign pc_o         = w_inst_valid ? w_head[EW-1:INST_W] : '0;

endmodule

// File: tb/tb_ysyx_22041207_ifu_prefetch.sv
// Randomised scoreboard bench for the prefetching fetch unit with a latency-modelled memory.
`timescale 1ns/1ps
module tb_ysyx_22041207_ifu_prefetch;
    import ysyx_22041207_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] pc_o;

    always #5 clk = ~clk;

    ysyx_22041207_ifu_prefetch #(
        .XLEN            (64),
        .RESET_PC        (RST_PC),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: each 32-bit word is a hash of its own address.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [31:0] h;
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [63:0] dword_at(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {word_at(b + 64'd4), word_at(b)};
    endfunction

    // Reference program order: sequential PCs from the last reset/redirect target.
    fetch_entry_t exp_q[$];
    logic [63:0]  model_pc;

    function automatic void sb_extend();
        fetch_entry_t e;
        e.pc   = model_pc;
        e.inst = word_at(model_pc);
        exp_q.push_back(e);
        model_pc = model_pc + 64'd4;
    endfunction

    function automatic void sb_restart(input logic [63:0] pc);
        exp_q.delete();
        model_pc = pc;
        for (int i = 0; i < 8; i++) sb_extend();
    endfunction

    // Monitor: compares every decode handshake against the reference stream.
    int           deq_cnt = 0;
    logic         last_resp_v = 1'b0;
    logic         last_deq = 1'b0;
    fetch_entry_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            last_resp_v = imem_resp_valid;
            last_deq    = inst_valid && inst_ready;
            if (inst_valid && inst_ready) begin
                deq_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got pc %h with no expected entry", pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("deq_pc", pc_o, mon_e.pc);
                    check("deq_inst", 64'(inst_o), 64'(mon_e.inst));
                    sb_extend();
                end
            end else if (!inst_valid) begin
                check("empty_pc", pc_o, 64'd0);
                check("empty_inst", 64'(inst_o), 64'd0);
            end
        end
    end

    // Memory model: in-order responses, per-request latency in [lat_lo, lat_hi].
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [63:0] fire_log[$];
    int          fire_cnt = 0;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          mem_hold = 1'b0;

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            fire_log.push_back(imem_req_addr);
            fire_cnt++;
        end
    end

    initial begin
        logic [63:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_resp_valid = 1'b0;
            imem_resp_data  = {$urandom, $urandom};
            if (!mem_hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                imem_resp_valid = 1'b1;
                imem_resp_data  = dword_at(a);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit keep_pend);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        cycle();
        if (!keep_pend) begin
            pend_addr.delete();
            pend_due.delete();
        end
        fire_log.delete();
        fire_cnt = 0;
        sb_restart(RST_PC);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        check("rst_pc_o", pc_o, 64'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [63:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        cycle();
        redirect_valid = 1'b0;
        sb_restart(t & ~64'd3);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int nfire;
        logic [63:0] t;
        bit do_rd;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;

        // Sequential fetch, 1-cycle memory, full throughput.
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (4) cycle();
        d0 = deq_cnt;
        repeat (6) cycle();
        check("throughput", 64'(deq_cnt - d0), 64'd6);
        check("fire_log_len_ok", 64'(fire_log.size() >= 3), 64'd1);
        if (fire_log.size() >= 3) begin
            check("addr0", fire_log[0], 64'h8000_0000);
            check("addr1", fire_log[1], 64'h8000_0004);
            check("addr2", fire_log[2], 64'h8000_0008);
        end

        // Decode stalled: exactly FQ_DEPTH entries fetched, then drained in order.
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (12) cycle();
        check("fill_inst_valid", 64'(inst_valid), 64'd1);
        check("fill_req_valid", 64'(imem_req_valid), 64'd0);
        check("fill_fire_cnt", 64'(fire_cnt), 64'd4);
        d0 = deq_cnt;
        inst_ready = 1'b1;
        repeat (8) cycle();
        check("fill_drain", 64'(deq_cnt - d0 >= 4), 64'd1);

        // Two stale requests in flight, then redirect to a misaligned target.
        do_reset(1'b0);
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 10 && fire_cnt < 2; i++) cycle();
        repeat (2) cycle();
        check("cap_fire_cnt", 64'(fire_cnt), 64'd2);
        check("cap_req_valid", 64'(imem_req_valid), 64'd0);
        nfire = fire_log.size();
        do_redirect(64'h8000_1003);
        check("redir_empty", 64'(inst_valid), 64'd0);
        check("redir_addr", imem_req_addr, 64'h8000_1000);
        d0 = deq_cnt;
        mem_hold = 1'b0;
        repeat (10) cycle();
        check("redir_fire_seen", 64'(fire_log.size() > nfire), 64'd1);
        if (fire_log.size() > nfire) check("redir_first_req", fire_log[nfire], 64'h8000_1000);
        check("redir_progress", 64'(deq_cnt - d0 > 0), 64'd1);

        // Redirect coinciding with a response and a dequeue.
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (6) cycle();
        do_redirect(64'h8000_2000);
        check("same_cycle_resp", 64'(last_resp_v), 64'd1);
        check("same_cycle_deq", 64'(last_deq), 64'd1);
        check("same_cycle_flush", 64'(inst_valid), 64'd0);
        d0 = deq_cnt;
        repeat (8) cycle();
        check("same_cycle_progress", 64'(deq_cnt - d0 > 0), 64'd1);

        // Memory back-pressure: address holds until the handshake completes.
        do_reset(1'b0);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_addr", imem_req_addr, RST_PC);
            check("stall_valid", 64'(imem_req_valid), 64'd1);
        end
        imem_req_ready = 1'b1;
        cycle();
        check("stall_advance", imem_req_addr, RST_PC + 64'd4);
        check("stall_fire_cnt", 64'(fire_cnt), 64'd1);

        // Reset mid-operation with responses still in flight.
        do_reset(1'b0);
        lat_lo         = 4;
        lat_hi         = 4;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (7) cycle();
        check("midrst_pre_valid", 64'(inst_valid), 64'd1);
        imem_req_ready = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("midrst_stray_ignored", 64'(inst_valid), 64'd0);
        end

        // Randomised traffic with occasional redirects, including one across the address wrap.
        lat_lo = 1;
        lat_hi = 4;
        d0     = deq_cnt;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(9, 0) < 7);
            do_rd = (i == 1000) || ($urandom_range(39, 0) == 0);
            if (do_rd) begin
                t = (i == 1000) ? 64'hFFFF_FFFF_FFFF_FFF6 : {$urandom, $urandom};
                do_redirect(t);
            end else begin
                cycle();
            end
        end
        check("random_progress", 64'(deq_cnt - d0 > 300), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_ifu_prefetch.md
Name: ysyx_22041207_ifu_prefetch

Overview:
Parametrised instruction-fetch unit with a prefetch queue, replacing the single-register fetch stage.
- Issues sequential fetch requests over a valid/ready memory interface, with up to MAX_OUTSTANDING requests in flight.
- Buffers in-order responses as {pc, inst} entries in an FQ_DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- EX-stage redirects (jal/jalr/taken branch, target already computed) flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h8000_0000, first fetch address after reset
FQ_DEPTH, 4, prefetch queue entries; power of 2, >=2
MAX_OUTSTANDING, 2, max in-flight memory requests; 1..FQ_DEPTH

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  EX redirect this cycle
redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0 internally
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (current fetch_pc)
imem_resp_valid  in  1  response valid; in order, always accepted
imem_resp_data  in  64  aligned doubleword; word selected by pc[2]
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_o  out  32  head instruction; 0 when queue empty
pc_o  out  XLEN  head PC; 0 when queue empty

Behaviour:
- Reset (sync, rst=1 at posedge):
  - fetch_pc <= RESET_PC; resp_pc <= RESET_PC.
  - Queue count, head and tail, outstanding counter O, and drop counter D all <= 0.
  - Outputs then read inst_valid=0, imem_req_valid=0, inst_o=0, pc_o=0, imem_req_addr=RESET_PC.
  - Reset mid-operation discards everything. Responses arriving while O==0 are ignored.
- Request issue:
  - imem_req_valid = !redirect_valid && (O < MAX_OUTSTANDING) && (count + O - D < FQ_DEPTH). This credit rule guarantees every kept response has a free slot.
  - req_fire = imem_req_valid && imem_req_ready. On fire: fetch_pc += 4 and O increments.
  - imem_req_addr is held stable while valid and not ready.
- Response (resp_valid with O>0): O decrements.
  - If D>0: the response is discarded, D decrements, and resp_pc is unchanged.
  - Otherwise: push {resp_pc, resp_pc[2] ? data[63:32] : data[31:0]} and resp_pc += 4.
- Dequeue: deq = inst_valid && inst_ready. The head advances and count decrements.
- Simultaneous push and dequeue: count is unchanged. Push into a full queue is impossible; flag it with an assertion.
- Redirect (highest priority over push, dequeue and issue):
  - count <= 0 and head = tail.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; resp_pc <= the same value.
  - D <= O - (resp_valid ? 1 : 0), so a response in the same cycle is dropped. O updates normally.
  - A dequeue in the same cycle is still a completed handshake; decode owns squashing that instruction.
  - No request is issued in the redirect cycle; normal issue resumes on the next cycle.
  - Back-to-back redirects: each recomputes D from the current O.
- Latency:
  - Redirect to first request: 1 cycle.
  - Response to inst_valid: 1 cycle (registered queue, no bypass).
  - Steady state: 1 instruction per cycle when memory responds with latency <= MAX_OUTSTANDING.
- Width rules: PC arithmetic is modulo 2^XLEN; wrap at all-ones is silent. Counters are clog2(FQ_DEPTH)+1 bits wide.

Decomposition:
- Shared package ysyx_22041207_pkg holds:
  - RESET_PC default and INST_W=32;
  - fetch-entry typedef {pc, inst};
  - the PC increment constant 4.
- Sub-module ysyx_22041207_fetch_fifo: a generic sync FIFO (push, pop, flush, count, head data) parametrised by depth and entry width. The top holds fetch_pc, resp_pc, O, D and the issue logic.

Test Plan:
- Reset then imem_req_ready=1 and 1-cycle response latency: first addresses 0x80000000, 0x80000004, 0x80000008. Decode receives pc_o 0x80000000 with inst = low word, then 0x80000004 with inst = high word, one per cycle.
- inst_ready=0 held: exactly FQ_DEPTH=4 entries fill. imem_req_valid drops when count+O-D reaches 4. No entry is lost or overwritten, and order is preserved after inst_ready=1.
- Two requests outstanding (0x80000000, 0x80000004), then redirect_pc=0x80001003: both old responses are dropped (D=2). The next request is 0x80001000, the first dequeued pc_o=0x80001000, and the queue is empty in the cycle after redirect.
- Redirect in the same cycle as resp_valid and deq: the response is discarded, count=0 next cycle, D equals O after the cycle, and the handshake in that cycle counts as one dequeue.
- imem_req_ready held low 5 cycles: imem_req_addr is stable at 0x80000000, and fetch_pc advances only on fire.
- rst asserted with O=2 and a full queue: the next cycle shows inst_valid=0 and imem_req_addr=RESET_PC. Late stray responses are ignored.
